// File: rtl/nn_pkg.sv
// Shared fixed-point helpers for the neuron datapath, so the feeder and the
// accumulator derive their widths and binary points from the same rules.
package nn_pkg;

   typedef struct packed {
      logic valid;
      logic last;
   } stage_tag_t;

   function automatic int fx_point(input int width, input int int_bits);
      return width - int_bits;
   endfunction

   function automatic int prod_width(input int a_width, input int b_width);
      return a_width + b_width;
   endfunction

   function automatic int prod_int(input int a_int, input int b_int);
      return a_int + b_int;
   endfunction

endpackage

// File: rtl/weight_ram.sv
// Weight storage: one write port and one registered, read-first read port.
module weight_ram #(
   parameter int DEPTH      = 16,
   parameter int WIDTH      = 16,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [WIDTH-1:0]      rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Contents survive reset; a same-edge write to the read address returns the old word.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/neuron_mac_feed.sv
// Activation x weight feeder for the neuron accumulator: a 3-stage product pipeline
// with en/last framing and a forced one-cycle bubble after every last sample.
module neuron_mac_feed
   import nn_pkg::*;
#(
   parameter int DIN_WIDTH  = 16,
   parameter int DIN_INT    = 4,
   parameter int W_WIDTH    = 16,
   parameter int W_INT      = 4,
   parameter int N_INPUTS   = 16,
   parameter int ADDR_WIDTH = $clog2(N_INPUTS)
) (
   input  logic                                           clk,
   input  logic                                           rst,
   input  logic [DIN_WIDTH-1:0]                           din,
   input  logic                                           din_valid,
   output logic                                           din_ready,
   input  logic                                           w_we,
   input  logic [ADDR_WIDTH-1:0]                          w_addr,
   input  logic [W_WIDTH-1:0]                             w_din,
   output logic [nn_pkg::prod_width(DIN_WIDTH, W_WIDTH)-1:0] dout,
   output logic                                           dout_en,
   output logic                                           dout_last,
   output logic                                           busy
);

   localparam int DOUT_WIDTH = prod_width(DIN_WIDTH, W_WIDTH);
   localparam int DOUT_INT   = prod_int(DIN_INT, W_INT);
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(N_INPUTS - 1);

   if (N_INPUTS < 2 || fx_point(DOUT_WIDTH, DOUT_INT) < 0) begin : g_bad_cfg
      $error("neuron_mac_feed: unsupported configuration");
   end

   logic [ADDR_WIDTH-1:0]        idx;
   logic                         ready_q;
   logic                         xfer;
   logic                         xfer_last;
   stage_tag_t                   s0_tag;
   stage_tag_t                   s1_tag;
   stage_tag_t                   s2_tag;
   logic signed [DIN_WIDTH-1:0]  s0_din;
   logic signed [W_WIDTH-1:0]    s0_w;
   logic signed [DOUT_WIDTH-1:0] s1_prod;
   logic signed [DOUT_WIDTH-1:0] s2_prod;

   assign xfer      = din_valid & ready_q;
   assign xfer_last = xfer & (idx == LAST_IDX);

   // The RAM read is the S0 weight register, addressed by the activation's index.
   weight_ram #(
      .DEPTH      (N_INPUTS),
      .WIDTH      (W_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_weight_ram (
      .clk     (clk),
      .we      (w_we),
      .wr_addr (w_addr),
      .wr_data (w_din),
      .rd_en   (xfer),
      .rd_addr (idx),
      .rd_data (s0_w)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx     <= '0;
         ready_q <= 1'b0;
      end else begin
         ready_q <= ~xfer_last;
         if (xfer_last) begin
            idx <= '0;
         end else if (xfer) begin
            idx <= idx + 1'b1;
         end
      end
   end

   // Tags shift every cycle; data registers only load behind a valid tag so dout holds when idle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s0_tag  <= '0;
         s1_tag  <= '0;
         s2_tag  <= '0;
         s0_din  <= '0;
         s1_prod <= '0;
         s2_prod <= '0;
      end else begin
         s0_tag.valid <= xfer;
         s0_tag.last  <= xfer_last;
         s1_tag       <= s0_tag;
         s2_tag       <= s1_tag;
         if (xfer) begin
            s0_din <= din;
         end
         if (s0_tag.valid) begin
            s1_prod <= DOUT_WIDTH'(s0_din) * DOUT_WIDTH'(s0_w);
         end
         if (s1_tag.valid) begin
            s2_prod <= s1_prod;
         end
      end
   end

   assign din_ready = ready_q;
   assign dout      = s2_prod;
   assign dout_en   = s2_tag.valid;
   assign dout_last = s2_tag.valid & s2_tag.last;
   assign busy      = (idx != '0) | s0_tag.valid | s1_tag.valid | s2_tag.valid;

endmodule

// File: tb/tb_neuron_mac_feed.sv
// Directed bench for neuron_mac_feed with N_INPUTS=4 and 16/4 formats (1.0 = 0x1000).
module tb_neuron_mac_feed;

   localparam int N = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] din = '0;
   logic        din_valid = 1'b0;
   logic        din_ready;
   logic        w_we = 1'b0;
   logic [1:0]  w_addr = '0;
   logic [15:0] w_din = '0;
   logic [31:0] dout;
   logic        dout_en;
   logic        dout_last;
   logic        busy;

   typedef struct {
      logic [31:0] prod;
      logic        last;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];
   int   last_cycs[$];
   int   cyc = 0;
   int   bubbles = 0;
   int   tests_run = 0;
   int   tests_failed = 0;

   logic [31:0] vec1_prod [N] = '{32'h0080_0000, 32'h0100_0000, 32'hFF80_0000, 32'h0200_0000};

   neuron_mac_feed #(
      .DIN_WIDTH (16),
      .DIN_INT   (4),
      .W_WIDTH   (16),
      .W_INT     (4),
      .N_INPUTS  (N)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .din_valid (din_valid),
      .din_ready (din_ready),
      .w_we      (w_we),
      .w_addr    (w_addr),
      .w_din     (w_din),
      .dout      (dout),
      .dout_en   (dout_en),
      .dout_last (dout_last),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_output(input string tag, input logic [63:0] actual, input logic [63:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Every product leaving the pipe is matched against the expectation queue, including its latency.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst) begin
         if (dout_last && !dout_en) check_output("last_without_en", 1, 0);
         if (dout_en) begin
            if (dout_last) last_cycs.push_back(cyc);
            if (exp_q.size() == 0) begin
               check_output("spurious_en", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check_output("dout", dout, e.prod);
               check_output("dout_last", dout_last, e.last);
               check_output("latency", cyc - e.cyc, 3);
            end
         end
      end
   end

   task automatic write_weight(input logic [1:0] addr, input logic [15:0] data);
      w_we   = 1'b1;
      w_addr = addr;
      w_din  = data;
      @(posedge clk); #1;
      w_we   = 1'b0;
   endtask

   task automatic apply_stimulus(input logic [15:0] act, input logic [31:0] prod,
                                 input logic last, input bit expect_it);
      int waits = 0;
      din       = act;
      din_valid = 1'b1;
      @(negedge clk);
      while (!din_ready && waits < 4) begin
         bubbles++;
         waits++;
         @(negedge clk);
      end
      if (!din_ready) check_output("ready_timeout", 0, 1);
      else if (expect_it) exp_q.push_back('{prod, last, cyc});
      @(posedge clk); #1;
      din_valid = 1'b0;
      w_we      = 1'b0;
   endtask

   task automatic idle(input int n);
      din_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain(input string tag);
      repeat (6) @(negedge clk);
      check_output({tag, "_drained"}, exp_q.size(), 0);
      check_output({tag, "_busy"}, busy, 0);
      @(posedge clk); #1;
   endtask

   task automatic apply_reset(input int n);
      rst = 1'b0;
      repeat (n) @(posedge clk);
      @(negedge clk);
      check_output("rst_dout", dout, 0);
      check_output("rst_dout_en", dout_en, 0);
      check_output("rst_dout_last", dout_last, 0);
      check_output("rst_din_ready", din_ready, 0);
      check_output("rst_busy", busy, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check_output("ready_before_edge", din_ready, 0);
      @(negedge clk);
      check_output("ready_after_edge", din_ready, 1);
      @(posedge clk); #1;
   endtask

   initial begin : watchdog
      #100000;
      check_output("watchdog", 0, 1);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      apply_reset(5);

      write_weight(2'd0, 16'h0800);
      write_weight(2'd1, 16'h1000);
      write_weight(2'd2, 16'hF800);
      write_weight(2'd3, 16'h2000);

      // Single vector, then the forced bubble on din_ready
      for (int i = 0; i < N; i++) apply_stimulus(16'h1000, vec1_prod[i], i == N - 1, 1'b1);
      @(negedge clk);
      check_output("gap_ready_low", din_ready, 0);
      @(negedge clk);
      check_output("gap_ready_high", din_ready, 1);
      @(posedge clk); #1;
      drain("single");

      // Two vectors with din_valid held high
      bubbles = 0;
      last_cycs.delete();
      for (int i = 0; i < 2 * N; i++) apply_stimulus(16'h1000, vec1_prod[i % N], (i % N) == N - 1, 1'b1);
      check_output("b2b_bubbles", bubbles, 1);
      drain("b2b");
      check_output("b2b_last_count", last_cycs.size(), 2);
      if (last_cycs.size() == 2) check_output("b2b_last_spacing", last_cycs[1] - last_cycs[0], 5);

      // din_valid toggling mid-vector
      apply_stimulus(16'h1000, 32'h0080_0000, 1'b0, 1'b1);
      idle(1);
      apply_stimulus(16'h2000, 32'h0200_0000, 1'b0, 1'b1);
      idle(2);
      check_output("stall_busy", busy, 1);
      apply_stimulus(16'h1000, 32'hFF80_0000, 1'b0, 1'b1);
      idle(3);
      apply_stimulus(16'hF000, 32'hFE00_0000, 1'b1, 1'b1);
      drain("stall");

      // Reset after two transfers drops them; the next vector restarts at weight[0]
      apply_stimulus(16'h1000, 32'h0, 1'b0, 1'b0);
      apply_stimulus(16'h1000, 32'h0, 1'b0, 1'b0);
      apply_reset(2);
      for (int i = 0; i < N; i++) apply_stimulus(16'h1000, vec1_prod[i], i == N - 1, 1'b1);
      drain("post_reset");

      // Extreme operands
      write_weight(2'd0, 16'h8000);
      write_weight(2'd1, 16'h8000);
      write_weight(2'd2, 16'h1000);
      write_weight(2'd3, 16'h1000);
      apply_stimulus(16'h8000, 32'h4000_0000, 1'b0, 1'b1);
      apply_stimulus(16'h7FFF, 32'hC000_8000, 1'b0, 1'b1);
      apply_stimulus(16'h1000, 32'h0100_0000, 1'b0, 1'b1);
      apply_stimulus(16'h1000, 32'h0100_0000, 1'b1, 1'b1);
      drain("extreme");

      // Idle weight write, usable by the next vector
      write_weight(2'd1, 16'h3000);
      apply_stimulus(16'h1000, 32'hF800_0000, 1'b0, 1'b1);
      apply_stimulus(16'h1000, 32'h0300_0000, 1'b0, 1'b1);
      apply_stimulus(16'h1000, 32'h0100_0000, 1'b0, 1'b1);
      apply_stimulus(16'h1000, 32'h0100_0000, 1'b1, 1'b1);
      drain("wr_idle");

      // Write to weight[0] on the same edge it is read: old value first, new value next vector
      w_we   = 1'b1;
      w_addr = 2'd0;
      w_din  = 16'h7000;
      apply_stimulus(16'h1000, 32'hF800_0000, 1'b0, 1'b1);
      apply_stimulus(16'h1000, 32'h0300_0000, 1'b0, 1'b1);
      apply_stimulus(16'h1000, 32'h0100_0000, 1'b0, 1'b1);
      apply_stimulus(16'h1000, 32'h0100_0000, 1'b1, 1'b1);
      drain("collision");
      apply_stimulus(16'h1000, 32'h0700_0000, 1'b0, 1'b1);
      apply_stimulus(16'h1000, 32'h0300_0000, 1'b0, 1'b1);
      apply_stimulus(16'h1000, 32'h0100_0000, 1'b0, 1'b1);
      apply_stimulus(16'h1000, 32'h0100_0000, 1'b1, 1'b1);
      drain("after_collision");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/neuron_mac_feed.md
# neuron_mac_feed

Upstream feeder for the signed accumulator in the neuron datapath. It accepts a stream of signed fixed-point input activations and multiplies each one by the matching weight from an internal weight RAM. It emits the full-precision products with the `en`/`last` framing the accumulator requires. The required framing is a one-cycle bubble after every `last`, which this block enforces.

## Interface
Parameters:
- `DIN_WIDTH`, 16, input activation width (signed)
- `DIN_INT`, 4, integer bits of activation
- `W_WIDTH`, 16, weight width (signed)
- `W_INT`, 4, integer bits of weight
- `N_INPUTS`, 16, vector length (neuron fan-in), ≥2
- `ADDR_WIDTH`, $clog2(N_INPUTS), weight address width
- Derived, not overridable: `DOUT_WIDTH = DIN_WIDTH+W_WIDTH`, `DOUT_INT = DIN_INT+W_INT`

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-low
- `din`  in  DIN_WIDTH  signed activation
- `din_valid`  in  1  activation present
- `din_ready`  out  1  block accepts `din` this cycle
- `w_we`  in  1  weight write strobe
- `w_addr`  in  ADDR_WIDTH  weight write address
- `w_din`  in  W_WIDTH  weight write data
- `dout`  out  DOUT_WIDTH  signed product, to accumulator `din`
- `dout_en`  out  1  product valid, to accumulator `en`
- `dout_last`  out  1  final product of vector, to accumulator `last`
- `busy`  out  1  vector in progress or pipeline non-empty

## Operation
- Transfer occurs when `din_valid & din_ready`. Activation k of a vector (k = index counter, 0..N_INPUTS-1) multiplies weight[k].
- Index counter:
  - increments per transfer;
  - wraps to 0 after N_INPUTS-1;
  - the transfer at N_INPUTS-1 is tagged last.
- Gap rule: the cycle after a last transfer, `din_ready` = 0 (one forced bubble). Otherwise `din_ready` = 1. No other backpressure.
- Product arithmetic:
  - exact signed product, no rounding or saturation;
  - binary point at `DOUT_WIDTH-DOUT_INT`.
- Pipeline, 3 registered stages, each carrying valid and last:
  - S0: capture `din`; weight RAM read.
  - S1: multiply register.
  - S2: output register.
- Stage valid bits shift every cycle (no stall).
- `dout_en` = S2 valid; `dout_last` = S2 valid & S2 last.
- Consequence: `dout_en` and `dout_last` are both low the cycle after `dout_last`.
- When S2 is invalid, `dout` holds its previous value (don't-care for the consumer).
- Weight writes:
  - accepted any cycle;
  - same-cycle read of the same address returns old data (read-first);
  - software writes only while `busy` = 0 for defined results.
- `busy` = (index ≠ 0) | any stage valid.
- Reset asserted (any time, including mid-vector):
  - index → 0, all valids → 0;
  - `dout` = 0, `dout_en` = 0, `dout_last` = 0, `din_ready` = 0, `busy` = 0;
  - weight RAM contents are not cleared.
- First rising edge after reset release: `din_ready` → 1.
- `din_valid` low mid-vector: index holds; the partial vector resumes on the next transfer.

## Timing
- Latency: transfer at edge t → `dout_en` high after edge t+3 (3 cycles).
- Throughput:
  - N_INPUTS samples per N_INPUTS+1 cycles back-to-back;
  - one vector per N_INPUTS+1 cycles sustained.
- `din_ready` is registered and depends only on the previous cycle's transfer.
- Weight write latency: 1 cycle. A written value is readable by the transfer on the following cycle.
- Simultaneous reset and transfer: reset wins; the sample is dropped.

## Structure
- Shared package `nn_pkg`:
  - fixed-point point/width helper functions (point = width − int);
  - product width rule `DOUT_WIDTH = DIN_WIDTH+W_WIDTH` and `DOUT_INT = DIN_INT+W_INT`, so the accumulator's alignment parameters are set from the same constants.
- One sub-module `weight_ram`:
  - N_INPUTS × W_WIDTH;
  - single write port, single registered read port, read-first.
- Counter, gap flag and 3-stage pipeline live in the top.

## Test plan
Test configuration: N_INPUTS=4, 16/4 formats, so 1.0 = 0x1000 and 0.5 = 0x0800.
- Reset values: reset held 5 cycles → all outputs 0. `din_ready` rises exactly one edge after release.
- Single vector: weights {0x0800, 0x1000, 0xF800, 0x2000}, activations all 0x1000 streamed back-to-back → `dout` = 0x00800000, 0x01000000, 0xFF800000, 0x02000000. `dout_en` begins 3 cycles after the first transfer. `dout_last` is on the 4th product only. `din_ready` is 0 the cycle after the 4th transfer.
- Back-to-back vectors: 8 activations with `din_valid` held high → exactly one bubble cycle between the two vectors on both `din_ready` and `dout_en`. Two `dout_last` pulses, 5 cycles apart.
- Extreme values: activation 0x8000 × weight 0x8000 → `dout` = 0x40000000. Activation 0x7FFF × weight 0x8000 → 0xC0008000.
- Stalls and reset: `din_valid` toggles mid-vector → products in order and last on the 4th product. Then reset asserted after 2 transfers, then a full vector → first product uses weight[0] and no stale `dout_en`.
- Weight-write timing: write weight[1] = 0x3000 while idle, then a vector with all activations = 0x1000 → second product = 0x03000000. A same-cycle write/read collision → old value is used.
